// File: rtl/priority_resolver.sv
// priority_resolver: 8259A-style priority resolver with fixed/rotating order and ISR nesting
module priority_resolver (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode,
   input  logic [7:0] interrupt_mask,
   input  logic [7:0] highest_level_in_service,
   input  logic [7:0] interrupt_request_register,
   input  logic [7:0] in_service_register,
   output logic [7:0] interrupt
);
   logic [2:0]  k;
   logic [2:0]  s;
   logic [7:0]  req;
   logic [15:0] req_dbl;
   logic [15:0] isr_dbl;
   logic [7:0]  rot_req;
   logic [7:0]  rot_isr;
   logic [7:0]  isr_top;
   logic [7:0]  eligible;
   logic [7:0]  rot_grant;
   logic [15:0] grant_dbl;
   logic [7:0]  grant;
   // lowest set bit of the reference is the lowest-priority level; none set or fixed mode means IR7
   always_comb begin
      k = 3'd7;
      for (int i = 7; i >= 0; i--)
         if (mode && highest_level_in_service[i]) k = i[2:0];
   end
   // rotate so the highest-priority level sits at bit 0, encode, then rotate the grant back
   always_comb begin
      s         = k + 3'd1;
      req       = interrupt_request_register & ~interrupt_mask;
      req_dbl   = {req, req} >> s;
      isr_dbl   = {in_service_register, in_service_register} >> s;
      rot_req   = req_dbl[7:0];
      rot_isr   = isr_dbl[7:0];
      isr_top   = rot_isr & -rot_isr;
      eligible  = rot_req & (isr_top - 8'd1);
      rot_grant = eligible & -eligible;
      grant_dbl = {rot_grant, rot_grant} << s;
      grant     = grant_dbl[15:8];
   end
   // single output register
   always_ff @(posedge clock)
      interrupt <= reset ? 8'h00 : grant;
endmodule

// File: tb/tb_priority_resolver.sv
// tb_priority_resolver: directed vectors plus a randomized model comparison
module tb_priority_resolver;
   logic       clock = 1'b0;
   logic       reset;
   logic       mode;
   logic [7:0] interrupt_mask;
   logic [7:0] highest_level_in_service;
   logic [7:0] interrupt_request_register;
   logic [7:0] in_service_register;
   logic [7:0] interrupt;
   int vectors = 0;
   int miscompares = 0;

   priority_resolver dut (
      .clock(clock),
      .reset(reset),
      .mode(mode),
      .interrupt_mask(interrupt_mask),
      .highest_level_in_service(highest_level_in_service),
      .interrupt_request_register(interrupt_request_register),
      .in_service_register(in_service_register),
      .interrupt(interrupt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic apply(input string tag, input logic m, input logic [7:0] imr, input logic [7:0] rf,
                        input logic [7:0] irr, input logic [7:0] isr, input logic [7:0] exp);
      mode = m;
      interrupt_mask = imr;
      highest_level_in_service = rf;
      interrupt_request_register = irr;
      in_service_register = isr;
      @(posedge clock);
      #1 check(tag, interrupt, exp);
   endtask

   function automatic logic [7:0] model(input logic m, input logic [7:0] imr, input logic [7:0] rf,
                                        input logic [7:0] irr, input logic [7:0] isr);
      int base = 0;
      int isr_pos = 8;
      logic [7:0] req = irr & ~imr;
      if (m)
         for (int i = 0; i < 8; i++)
            if (rf[i]) begin
               base = (i + 1) % 8;
               break;
            end
      for (int p = 0; p < 8; p++)
         if (isr[(base + p) % 8]) begin
            isr_pos = p;
            break;
         end
      for (int p = 0; p < isr_pos; p++)
         if (req[(base + p) % 8]) return 8'(1 << ((base + p) % 8));
      return 8'h00;
   endfunction

   initial begin
      logic [7:0] exp;
      logic [7:0] rf;
      reset = 1'b1;
      mode = 1'b0;
      interrupt_mask = 8'h00;
      highest_level_in_service = 8'h00;
      interrupt_request_register = 8'hFF;
      in_service_register = 8'h00;
      @(posedge clock);
      #1 check("reset", interrupt, 8'h00);
      reset = 1'b0;
      apply("fixed_basic", 0, 8'h00, 8'h00, 8'b11110100, 8'h00, 8'b00000100);
      reset = 1'b1;
      @(posedge clock);
      #1 check("reset_mid", interrupt, 8'h00);
      reset = 1'b0;
      apply("rot_zero_ref", 1, 8'h00, 8'h00, 8'b00000100, 8'h00, 8'b00000100);
      apply("rot_zero_ref_fixed", 1, 8'h00, 8'h00, 8'b11110110, 8'h00, 8'b00000010);
      apply("mask_one", 0, 8'b00000100, 8'h00, 8'b11110100, 8'h00, 8'b00010000);
      apply("mask_all", 0, 8'hFF, 8'h00, 8'b11110100, 8'h00, 8'h00);
      apply("nest_higher", 0, 8'h00, 8'h00, 8'b00001010, 8'b00000100, 8'b00000010);
      apply("nest_blocked", 0, 8'h00, 8'h00, 8'b00001100, 8'b00000010, 8'h00);
      apply("nest_same", 0, 8'h00, 8'h00, 8'b00000100, 8'b00000100, 8'h00);
      apply("nest_isr_irr", 0, 8'h00, 8'h00, 8'b00001100, 8'b00000100, 8'h00);
      apply("masked_isr_blocks", 0, 8'b00000001, 8'h00, 8'b00000010, 8'b00000001, 8'h00);
      apply("rot_wrap", 1, 8'h00, 8'b00000100, 8'b00000101, 8'h00, 8'b00000001);
      apply("rot_isr_wrap", 1, 8'h00, 8'b00010000, 8'b10000010, 8'b00000001, 8'b10000000);
      apply("rot_multi_ref", 1, 8'h00, 8'b00100100, 8'b00001001, 8'h00, 8'b00001000);
      apply("rot_ref7", 1, 8'h00, 8'b10000000, 8'b10000001, 8'h00, 8'b00000001);
      apply("rot_ref0", 1, 8'h00, 8'b00000001, 8'b10000001, 8'h00, 8'b10000000);
      apply("mode_back_fixed", 0, 8'h00, 8'b00000001, 8'b10000001, 8'h00, 8'b00000001);
      apply("none_pending", 1, 8'h00, 8'b00001000, 8'h00, 8'h00, 8'h00);
      for (int n = 0; n < 12000; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         mode = 1'($urandom);
         interrupt_mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         case ($urandom_range(0, 3))
            0: rf = 8'h00;
            1: rf = 8'($urandom);
            default: rf = 8'(1 << $urandom_range(0, 7));
         endcase
         highest_level_in_service = rf;
         interrupt_request_register = 8'($urandom);
         in_service_register = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
         exp = reset ? 8'h00 : model(mode, interrupt_mask, rf, interrupt_request_register, in_service_register);
         @(posedge clock);
         #1;
         check("random", interrupt, exp);
         check("onehot", 8'((interrupt & (interrupt - 8'd1)) == 8'h00), 8'h01);
      end
      reset = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/priority_resolver.md
Name: priority_resolver

Overview:
- Priority resolver of an 8259A-style programmable interrupt controller.
- Each cycle it takes the interrupt request register (IRR), the interrupt mask (IMR), the in-service register (ISR) and the rotation reference, and selects the single highest-priority pending request that may interrupt the current service.
- Result is a registered one-hot grant vector, consumed by the control logic that drives INT and sets the ISR during the INTA sequence.

Parameters:
- None. Fixed 8 interrupt levels, IR0..IR7.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fully nested fixed priority; 1 = rotating priority.
- interrupt_mask  input  8  IMR; bit n = 1 masks IRn.
- highest_level_in_service  input  8  one-hot rotation reference; the set bit marks the lowest-priority level in rotating mode.
- interrupt_request_register  input  8  IRR; bit n = 1 means IRn is pending.
- in_service_register  input  8  ISR; bit n = 1 means IRn is being serviced.
- interrupt  output  8  registered one-hot grant; 0 = no grant.

Behaviour:
- Reset: synchronous, active-high. At a rising edge with reset = 1, interrupt <= 8'h00; reset has priority over everything else. No other state exists.
- Latency: one cycle. Inputs sampled at rising edge N appear on interrupt after edge N. Outputs never change between edges.

Candidate set and priority order:
- Candidates are the unmasked pending requests: masked_req = IRR & ~IMR.
- Fixed mode (mode = 0): IR0 highest, IR7 lowest.
- Rotating mode (mode = 1): let k = index of the set bit of highest_level_in_service. IRk is lowest priority and IR((k+1) mod 8) is highest, continuing upward with wrap-around.
  - highest_level_in_service = 0 in rotating mode: behave as k = 7, identical to fixed order.
  - Multiple bits set: the lowest-numbered set bit defines k.

Nesting rule (both modes):
- Find the highest-priority set bit of the ISR under the current priority order.
- A candidate is eligible only if its priority is strictly higher than that ISR level.
- Equal or lower priority levels are blocked.
- ISR = 0 blocks nothing.
- The ISR is not ANDed with the mask; masked in-service levels still block.

Grant:
- interrupt = one-hot of the highest-priority eligible candidate, otherwise 8'h00.
- Never more than one bit set.

Implementation guidance:
- Rotate masked_req and the ISR right by (k+1) mod 8.
- Run a fixed LSB-first priority encode and a mask-of-higher-levels on each.
- Rotate the resulting one-hot grant left by the same amount.
- Everything purely combinational up to the single output register.

Boundary cases:
- All requests masked -> 0.
- A request on the same level as the ISR -> 0.
- The IRR bit of an in-service level may also be set; it is still blocked.
- Mode changes take effect on the next edge with no history.

Test Plan:
- Fixed basic: reset, then mode=0, IMR=00, ISR=00, ref=00, IRR=8'b11110100 -> interrupt=8'b00000100 one cycle later; assert reset -> 8'h00 next edge.
- Rotating, zero reference: mode=1, ref=00, IRR=8'b00000100, IMR=00, ISR=00 -> interrupt=8'b00000100.
- Masking: mode=0, IMR=8'b00000100, IRR=8'b11110100 -> 8'b00010000; IMR=8'hFF -> 8'h00.
- Nesting, fixed: ISR=8'b00000100, IRR=8'b00001010 -> 8'b00000010; ISR=8'b00000010, IRR=8'b00001100 -> 8'h00; ISR=8'b00000100, IRR=8'b00000100 -> 8'h00.
- Rotation wrap:
  - mode=1, ref=8'b00000100, IRR=8'b00000101, ISR=00 -> 8'b00000001 (IR0 beats IR2).
  - ref=8'b00010000, ISR=8'b00000001, IRR=8'b10000010 -> 8'b10000000 (IR7 beats in-service IR0; IR1 blocked).
- Exhaustive/random: compare against a reference model over random mode/IMR/ISR/IRR/one-hot ref for ≥10k cycles, including reset asserted mid-stream. Output must be one-hot or zero and match with 1-cycle latency.
